// File: rtl/tbuf_bus_arbiter_if.sv
// Bus-side signal bundle for tbuf_bus_arbiter: requests in, TBUF enables and status out.
// master = arbiter side, slave = requester / TBUF side.
interface tbuf_bus_arbiter_if #(
  parameter int unsigned N_DRV = 4
);
  localparam int unsigned OwnerW = $clog2(N_DRV);

  logic [N_DRV-1:0]  req;
  logic [N_DRV-1:0]  en;
  logic [N_DRV-1:0]  gnt;
  logic [OwnerW-1:0] owner;
  logic              busy;
  logic              to;

  modport master (input req, output en, gnt, owner, busy, to);
  modport slave  (output req, input en, gnt, owner, busy, to);
endinterface

// File: rtl/tbuf_bus_arbiter.sv
// Round-robin arbiter driving one-hot-or-zero TBUFX1 enables with a turnaround gap.
// Optional tenure timeout enabled by defining TBUF_TIMEOUT_EN.
module tbuf_bus_arbiter #(
  parameter int unsigned N_DRV     = 4,
  parameter int unsigned TA_CYCLES = 1,
  parameter int unsigned MAX_HOLD  = 16
) (
  input logic                clk,
  input logic                rst_n,
  tbuf_bus_arbiter_if.master bus
);

  localparam int unsigned OwnerW = $clog2(N_DRV);
  localparam int unsigned TcntW  = (TA_CYCLES > 1) ? $clog2(TA_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StDrive, StTurn} state_e;

  state_e            state_q, state_d;
  logic [N_DRV-1:0]  en_q, en_d;
  logic [OwnerW-1:0] owner_q, owner_d;
  logic [OwnerW-1:0] rr_ptr_q, rr_ptr_d;
  logic [TcntW-1:0]  tcnt_q, tcnt_d;

  logic [N_DRV-1:0]  arb_req;
  logic              arb_found;
  logic [OwnerW-1:0] arb_win;
  logic [OwnerW-1:0] arb_next_ptr;
  logic              do_arb;
  int unsigned       idx;

`ifdef TBUF_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             to_q, to_d;
  logic [N_DRV-1:0] blocked_q, blocked_d;
  logic [N_DRV-1:0] masked_req;
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
`endif

  // Scan upward from rr_ptr with wrap; first set bit wins.
  always_comb begin
`ifdef TBUF_TIMEOUT_EN
    // A timed-out owner waits for its REQ to drop, unless nobody else is asking.
    masked_req = bus.req & ~blocked_q;
    arb_req    = (|masked_req) ? masked_req : bus.req;
`else
    arb_req    = bus.req;
`endif
    arb_found = 1'b0;
    arb_win   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < N_DRV; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= N_DRV) idx = idx - N_DRV;
      if (!arb_found && arb_req[idx[OwnerW-1:0]]) begin
        arb_found = 1'b1;
        arb_win   = idx[OwnerW-1:0];
      end
    end
    arb_next_ptr = (arb_win == OwnerW'(N_DRV - 1)) ? '0 : arb_win + OwnerW'(1);
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    tcnt_d   = tcnt_q;
    do_arb   = 1'b0;
`ifdef TBUF_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    to_d       = 1'b0;
    blocked_d  = blocked_q & bus.req;
`endif

    unique case (state_q)
      StIdle: do_arb = 1'b1;
      StDrive: begin
        if (!bus.req[owner_q]) begin
          en_d    = '0;
          tcnt_d  = TcntW'(TA_CYCLES - 1);
          state_d = StTurn;
`ifdef TBUF_TIMEOUT_EN
        end else if (hold_cnt_q == HoldW'(MAX_HOLD)) begin
          en_d               = '0;
          tcnt_d             = TcntW'(TA_CYCLES - 1);
          state_d            = StTurn;
          to_d               = 1'b1;
          blocked_d[owner_q] = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
`endif
        end
      end
      StTurn: begin
        if (tcnt_q != '0) tcnt_d = tcnt_q - TcntW'(1);
        else              do_arb = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (do_arb) begin
      if (arb_found) begin
        en_d          = '0;
        en_d[arb_win] = 1'b1;
        owner_d       = arb_win;
        rr_ptr_d      = arb_next_ptr;
        state_d       = StDrive;
`ifdef TBUF_TIMEOUT_EN
        hold_cnt_d    = HoldW'(1);
`endif
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      en_q     <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      tcnt_q   <= tcnt_d;
    end
  end

`ifdef TBUF_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      to_q       <= 1'b0;
      blocked_q  <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      to_q       <= to_d;
      blocked_q  <= blocked_d;
    end
  end

  assign bus.to = to_q;
`else
  assign bus.to = 1'b0;
`endif

  assign bus.en    = en_q;
  assign bus.gnt   = en_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q == StDrive);

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Directed bench for tbuf_bus_arbiter: reset, single/round-robin tenures, turnaround,
// timeout (when TBUF_TIMEOUT_EN is defined) and a random soak with per-cycle invariants.
module tb_tbuf_bus_arbiter;

  logic clk;
  logic clk_run;
  logic rst_n;
  int   checks;
  int   errors;
  logic [3:0] prev_a;
  logic [3:0] prev_b;

  tbuf_bus_arbiter_if #(.N_DRV(4)) a_if ();
  tbuf_bus_arbiter_if #(.N_DRV(4)) b_if ();

  tbuf_bus_arbiter #(.N_DRV(4), .TA_CYCLES(1), .MAX_HOLD(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  tbuf_bus_arbiter #(.N_DRV(4), .TA_CYCLES(3), .MAX_HOLD(16)) u_dut_ta3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check the enable invariants on both instances.
  task automatic tick();
    @(negedge clk);
    check("a_onehot0", 32'($onehot0(a_if.en)), 32'd1);
    check("b_onehot0", 32'($onehot0(b_if.en)), 32'd1);
    if (prev_a != 4'd0 && a_if.en != 4'd0) check("a_no_switch", 32'(a_if.en), 32'(prev_a));
    if (prev_b != 4'd0 && b_if.en != 4'd0) check("b_no_switch", 32'(b_if.en), 32'(prev_b));
    prev_a = a_if.en;
    prev_b = b_if.en;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    prev_a   = '0;
    prev_b   = '0;
    clk_run  = 1'b0;
    rst_n    = 1'b0;
    a_if.req = 4'b1111;
    b_if.req = 4'b0000;

    // Reset with no clock running
    #3;
    check("rst_en", 32'(a_if.en), 32'd0);
    check("rst_busy", 32'(a_if.busy), 32'd0);
    check("rst_owner", 32'(a_if.owner), 32'd0);
    check("rst_to", 32'(a_if.to), 32'd0);
    clk_run = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("first_en", 32'(a_if.en), 32'b0001);
    check("first_owner", 32'(a_if.owner), 32'd0);
    check("first_busy", 32'(a_if.busy), 32'd1);
    a_if.req = 4'b0000;
    tick();
    check("first_release_en", 32'(a_if.en), 32'd0);
    check("first_release_busy", 32'(a_if.busy), 32'd0);
    tick();
    check("idle_en", 32'(a_if.en), 32'd0);

    // Single requester, 5-cycle tenure
    a_if.req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("single_en", 32'(a_if.en), 32'b0100);
      check("single_gnt", 32'(a_if.gnt), 32'b0100);
      check("single_owner", 32'(a_if.owner), 32'd2);
    end
    a_if.req = 4'b0000;
    tick();
    check("single_gap_en", 32'(a_if.en), 32'd0);
    tick();
    check("single_idle_en", 32'(a_if.en), 32'd0);
    check("single_idle_busy", 32'(a_if.busy), 32'd0);

    // rr_ptr=3; scan wraps past 3 to grant 0, then reset mid-tenure
    a_if.req = 4'b0011;
    tick();
    check("wrap_scan_en", 32'(a_if.en), 32'b0001);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_en", 32'(a_if.en), 32'd0);
    check("async_rst_busy", 32'(a_if.busy), 32'd0);
    check("async_rst_owner", 32'(a_if.owner), 32'd0);
    tick();
    rst_n    = 1'b1;

    // Round-robin; first grant after reset must restart at 0
    a_if.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_en_first", 32'(a_if.en), 32'd1 << (k % 4));
      check("rr_owner", 32'(a_if.owner), 32'(k % 4));
      tick();
      check("rr_en_second", 32'(a_if.en), 32'd1 << (k % 4));
      a_if.req[k % 4] = 1'b0;
      tick();
      check("rr_gap_en", 32'(a_if.en), 32'd0);
      if (k < 4) a_if.req[k % 4] = 1'b1;
      else       a_if.req = 4'b0000;
    end
    tick();
    check("rr_idle_busy", 32'(a_if.busy), 32'd0);

    // rr_ptr=1: several requests, lowest index >=1 wins; one-cycle glitch tenure
    a_if.req = 4'b0101;
    tick();
    check("multi_en", 32'(a_if.en), 32'b0100);
    a_if.req = 4'b0000;
    tick();
    check("glitch_release_en", 32'(a_if.en), 32'd0);
    tick();
    check("glitch_idle_busy", 32'(a_if.busy), 32'd0);

    // TA_CYCLES=3 instance: owner 1 releases while 3 waits
    b_if.req = 4'b0010;
    tick();
    check("ta3_grant1", 32'(b_if.en), 32'b0010);
    b_if.req = 4'b1010;
    tick();
    check("ta3_hold1", 32'(b_if.en), 32'b0010);
    b_if.req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ta3_gap", 32'(b_if.en), 32'd0);
    end
    tick();
    check("ta3_grant3", 32'(b_if.en), 32'b1000);
    b_if.req = 4'b0000;
    tick();

`ifdef TBUF_TIMEOUT_EN
    tick();
    rst_n = 1'b0;
    tick();
    rst_n    = 1'b1;
    a_if.req = 4'b0011;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("to_hold_en", 32'(a_if.en), 32'b0001);
      check("to_hold_to", 32'(a_if.to), 32'd0);
    end
    tick();
    check("to_release_en", 32'(a_if.en), 32'd0);
    check("to_pulse", 32'(a_if.to), 32'd1);
    tick();
    check("to_next_en", 32'(a_if.en), 32'b0010);
    check("to_pulse_end", 32'(a_if.to), 32'd0);
    a_if.req = 4'b0000;
    tick();
    tick();
`else
    // rr_ptr=3: wrap grants 0; tenure is unbounded and TO stays low
    a_if.req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("long_hold_en", 32'(a_if.en), 32'b0001);
      check("long_hold_to", 32'(a_if.to), 32'd0);
    end
    a_if.req = 4'b0000;
    tick();
    tick();
`endif

    // Random soak: invariants are checked in tick()
    for (int i = 0; i < 10000; i++) begin
      a_if.req = 4'($urandom);
      b_if.req = 4'($urandom);
      tick();
    end
    a_if.req = 4'b0000;
    b_if.req = 4'b0000;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
